// File: rtl/ssid_sequencer.sv
// ssid_sequencer
// Generates one SSID / hit-memory address per accepted valid/ready transfer.
// Modes: 0 = linear count 0..countLimit, 1 = single pass over the loaded
// SSID table, 2 = continuous table loop, 3 = behaves as mode 0.
//
// Ports
//   clock, reset     : system clock (posedge) and synchronous active-high reset
//   start, stop      : begin a sequence (IDLE only) / abort it (RUN only)
//   mode             : sequence mode, latched at start
//   countLimit       : last SSID emitted in count mode (inclusive)
//   tableLen         : number of valid table entries, clamped to TABLEDEPTH
//   tableWrEn/Addr/Data : table write port, honoured only in IDLE
//   storageReady     : downstream accepts the presented address
//   SSID, hitInfo    : presented address, hitInfo is SSID zero-extended
//   newAddress       : SSID/hitInfo valid
//   busy, done       : sequence running / one-cycle end-of-sequence pulse
//   seqCount         : saturating count of transfers since the last start
module ssid_sequencer #(
    parameter int SSIDBITS      = 8,
    parameter int HITINFOBITS   = 16,
    parameter int TABLEDEPTH    = 32,
    parameter int TABLEADDRBITS = 5,
    parameter int COUNTBITS     = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic [1:0]               mode,
    input  logic [SSIDBITS-1:0]      countLimit,
    input  logic [TABLEADDRBITS:0]   tableLen,
    input  logic                     tableWrEn,
    input  logic [TABLEADDRBITS-1:0] tableWrAddr,
    input  logic [SSIDBITS-1:0]      tableWrData,
    input  logic                     storageReady,
    output logic [SSIDBITS-1:0]      SSID,
    output logic [HITINFOBITS-1:0]   hitInfo,
    output logic                     newAddress,
    output logic                     busy,
    output logic                     done,
    output logic [COUNTBITS-1:0]     seqCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [TABLEADDRBITS:0] DEPTH_W = (TABLEADDRBITS+1)'(TABLEDEPTH);

    state_t                   r_state;
    logic [SSIDBITS-1:0]      r_table [TABLEDEPTH];
    logic [1:0]               r_mode;
    logic [SSIDBITS-1:0]      r_limit;
    logic [TABLEADDRBITS:0]   r_len;
    logic [TABLEADDRBITS-1:0] r_index;
    logic [SSIDBITS-1:0]      r_ssid;
    logic                     r_new;
    logic                     r_busy;
    logic                     r_done;
    logic [COUNTBITS-1:0]     r_count;

    logic                     w_wr_en;
    logic [SSIDBITS-1:0]      w_first;
    logic [1:0]               w_mode_in;
    logic [TABLEADDRBITS:0]   w_len_in;
    logic                     w_xfer;
    logic [TABLEADDRBITS-1:0] w_idx_next;
    logic                     w_last;
    logic [SSIDBITS-1:0]      w_next_ssid;

    assign w_wr_en   = tableWrEn && (r_state == S_IDLE);
    // A write to entry 0 in the same cycle as start must be visible as the
    // first element, so bypass the array for that case.
    assign w_first   = (w_wr_en && (tableWrAddr == '0)) ? tableWrData : r_table[0];
    assign w_mode_in = (mode == 2'd3) ? 2'd0 : mode;
    assign w_len_in  = (tableLen > DEPTH_W) ? DEPTH_W : tableLen;
    assign w_xfer    = r_new && storageReady;
    assign w_idx_next = r_index + 1'b1;
    // r_len is never 0 while in RUN for table modes, so the subtraction is safe.
    assign w_last    = (r_mode == 2'd0) ? (r_ssid == r_limit)
                                        : ({1'b0, r_index} == (r_len - 1'b1));
    assign w_next_ssid = (r_mode == 2'd0) ? (r_ssid + 1'b1) : r_table[w_idx_next];

    // Table storage carries no reset so it survives a sequencer reset.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_table[tableWrAddr] <= tableWrData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mode  <= 2'd0;
            r_limit <= '0;
            r_len   <= '0;
            r_index <= '0;
            r_ssid  <= '0;
            r_new   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode  <= w_mode_in;
                        r_limit <= countLimit;
                        r_len   <= w_len_in;
                        r_count <= '0;
                        r_index <= '0;
                        if ((w_mode_in != 2'd0) && (w_len_in == '0)) begin
                            // Empty table: finish without presenting anything.
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_new   <= 1'b1;
                            r_ssid  <= (w_mode_in == 2'd0) ? '0 : w_first;
                        end
                    end
                end
                S_RUN: begin
                    if (w_xfer && (r_count != '1)) begin
                        r_count <= r_count + 1'b1;
                    end
                    if (stop) begin
                        r_new   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else if (w_xfer) begin
                        if (w_last) begin
                            if (r_mode == 2'd2) begin
                                r_index <= '0;
                                r_ssid  <= r_table[0];
                            end else begin
                                r_new   <= 1'b0;
                                r_busy  <= 1'b0;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_index <= w_idx_next;
                            r_ssid  <= w_next_ssid;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign SSID       = r_ssid;
    assign hitInfo    = HITINFOBITS'(r_ssid);
    assign newAddress = r_new;
    assign busy       = r_busy;
    assign done       = r_done;
    assign seqCount   = r_count;

endmodule

// File: tb/tb_ssid_sequencer.sv
module tb_ssid_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [7:0]  countLimit;
    logic [5:0]  tableLen;
    logic        tableWrEn;
    logic [4:0]  tableWrAddr;
    logic [7:0]  tableWrData;
    logic        storageReady;
    logic [7:0]  SSID;
    logic [15:0] hitInfo;
    logic        newAddress;
    logic        busy;
    logic        done;
    logic [15:0] seqCount;

    ssid_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .countLimit(countLimit), .tableLen(tableLen), .tableWrEn(tableWrEn),
        .tableWrAddr(tableWrAddr), .tableWrData(tableWrData),
        .storageReady(storageReady), .SSID(SSID), .hitInfo(hitInfo),
        .newAddress(newAddress), .busy(busy), .done(done), .seqCount(seqCount)
    );

    always #5 clock = ~clock;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    bit         na_hist[$];
    int         done_cnt, done_cyc, hold_bad, hi_bad, na_cycles;
    logic [7:0] tb_table [32];

    task automatic write_entry(input logic [4:0] a, input logic [7:0] d);
        tableWrEn = 1'b1; tableWrAddr = a; tableWrData = d;
        @(posedge clock); #1;
        tableWrEn = 1'b0;
        tb_table[a] = d;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [7:0] lim, input logic [5:0] len);
        mode = m; countLimit = lim; tableLen = len; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Drives storageReady/stop per cycle and records what the DUT delivers.
    task automatic run_seq(input bit toggle, input int stop_after, input int poke_cyc, input int max_cyc);
        int xfer = 0;
        bit prev_na = 1'b0;
        bit prev_rdy = 1'b0;
        logic [7:0] prev_ssid = 8'h00;
        obs_q.delete(); na_hist.delete();
        done_cnt = 0; done_cyc = -1; hold_bad = 0; hi_bad = 0; na_cycles = 0;
        for (int c = 0; c < max_cyc; c++) begin
            storageReady = toggle ? (c % 2 == 1) : 1'b1;
            stop = (stop_after > 0) && (xfer == stop_after - 1);
            if (c == poke_cyc) begin
                start = 1'b1; mode = 2'd0;
                tableWrEn = 1'b1; tableWrAddr = 5'd0; tableWrData = 8'hEE;
            end else begin
                start = 1'b0; tableWrEn = 1'b0;
            end
            @(negedge clock);
            na_hist.push_back(newAddress);
            if (newAddress) na_cycles++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (prev_na && !prev_rdy && (!newAddress || SSID !== prev_ssid)) hold_bad++;
            if (hitInfo !== {8'h00, SSID}) hi_bad++;
            if (newAddress && storageReady) begin
                obs_q.push_back(SSID);
                xfer++;
            end
            prev_na = newAddress; prev_rdy = storageReady; prev_ssid = SSID;
            @(posedge clock); #1;
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        stop = 1'b0; start = 1'b0; tableWrEn = 1'b0; storageReady = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_vec++; if (SSID !== 8'h00) begin n_err++; $display("FAIL reset_ssid: got %02h want 00", SSID); end
        n_vec++; if (hitInfo !== 16'h0000) begin n_err++; $display("FAIL reset_hitinfo: got %04h want 0000", hitInfo); end
        n_vec++; if (newAddress !== 1'b0) begin n_err++; $display("FAIL reset_newaddr: got %b want 0", newAddress); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (seqCount !== 16'd0) begin n_err++; $display("FAIL reset_seqcount: got %0d want 0", seqCount); end
        @(posedge clock); #1;
        reset = 1'b0;
        $display("reset: checked");
    endtask

    task automatic test_count(input string nm, input logic [1:0] m, input logic [7:0] lim);
        logic [7:0] e, o;
        int n = int'(lim) + 1;
        for (int i = 0; i < n; i++) exp_q.push_back(8'(i));
        do_start(m, lim, 6'd0);
        run_seq(1'b0, -1, -1, n + 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL %s_ssid: missing, want %02h", nm, e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL %s_ssid: got %02h want %02h", nm, o, e); end end
        end
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL %s_extra: got %0d extra transfers want 0", nm, obs_q.size()); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL %s_done_pulses: got %0d want 1", nm, done_cnt); end
        n_vec++; if (done_cyc != n + 1) begin n_err++; $display("FAIL %s_done_cycle: got %0d want %0d", nm, done_cyc, n + 1); end
        n_vec++; if (na_cycles != n) begin n_err++; $display("FAIL %s_newaddr_cycles: got %0d want %0d", nm, na_cycles, n); end
        n_vec++; if (hi_bad != 0) begin n_err++; $display("FAIL %s_hitinfo: got %0d bad cycles want 0", nm, hi_bad); end
        n_vec++; if (seqCount !== 16'(n)) begin n_err++; $display("FAIL %s_seqcount: got %0d want %0d", nm, seqCount, n); end
        $display("%s: limit %02h, %0d transfers, done at cycle %0d", nm, lim, n, done_cyc);
    endtask

    task automatic test_table_once;
        logic [7:0] e, o;
        for (int i = 0; i < 23; i++) write_entry(5'(i), 8'((i * 8'h35 + 8'h06) ^ (i << 4)));
        for (int i = 0; i < 23; i++) exp_q.push_back(tb_table[i]);
        do_start(2'd1, 8'h00, 6'd23);
        run_seq(1'b1, -1, -1, 80);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL once_ssid: missing, want %02h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL once_ssid: got %02h want %02h", o, e); end end
        end
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL once_extra: got %0d want 0", obs_q.size()); end
        n_vec++; if (hold_bad != 0) begin n_err++; $display("FAIL once_hold: got %0d unstable cycles want 0", hold_bad); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL once_done_pulses: got %0d want 1", done_cnt); end
        n_vec++; if (seqCount !== 16'd23) begin n_err++; $display("FAIL once_seqcount: got %0d want 23", seqCount); end
        $display("table_once: 23 entries, ready toggling, done at cycle %0d", done_cyc);
    endtask

    task automatic test_write_start;
        logic [7:0] o;
        exp_q.push_back(8'hA5);
        tableWrEn = 1'b1; tableWrAddr = 5'd0; tableWrData = 8'hA5;
        do_start(2'd1, 8'h00, 6'd1);
        tableWrEn = 1'b0; tb_table[0] = 8'hA5;
        run_seq(1'b0, -1, -1, 10);
        n_vec++;
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hXX;
        if (o !== exp_q.pop_front()) begin n_err++; $display("FAIL write_start_ssid: got %02h want a5", o); end
        n_vec++; if (seqCount !== 16'd1) begin n_err++; $display("FAIL write_start_seqcount: got %0d want 1", seqCount); end
        $display("write_start: first element %02h", o);
    endtask

    task automatic test_loop;
        logic [7:0] e, o;
        write_entry(5'd0, 8'h11); write_entry(5'd1, 8'h22); write_entry(5'd2, 8'h33);
        for (int i = 0; i < 7; i++) exp_q.push_back(tb_table[i % 3]);
        do_start(2'd2, 8'h00, 6'd3);
        run_seq(1'b0, 7, -1, 30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL loop_ssid: missing, want %02h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL loop_ssid: got %02h want %02h", o, e); end end
        end
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL loop_extra: got %0d want 0", obs_q.size()); end
        n_vec++; if (na_hist.size() < 8 || na_hist[7] != 1'b0) begin n_err++; $display("FAIL loop_newaddr_drop: newAddress not low after stop"); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL loop_done_pulses: got %0d want 1", done_cnt); end
        n_vec++; if (seqCount !== 16'd7) begin n_err++; $display("FAIL loop_seqcount: got %0d want 7", seqCount); end
        $display("table_loop: stopped after 7 transfers, done at cycle %0d", done_cyc);
    endtask

    task automatic test_len0;
        do_start(2'd1, 8'h00, 6'd0);
        run_seq(1'b0, -1, -1, 10);
        n_vec++; if (done_cyc != 1) begin n_err++; $display("FAIL len0_done_cycle: got %0d want 1", done_cyc); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL len0_done_pulses: got %0d want 1", done_cnt); end
        n_vec++; if (na_cycles != 0) begin n_err++; $display("FAIL len0_newaddr: got %0d cycles want 0", na_cycles); end
        n_vec++; if (seqCount !== 16'd0) begin n_err++; $display("FAIL len0_seqcount: got %0d want 0", seqCount); end
        $display("len0: done at cycle %0d, newAddress cycles %0d", done_cyc, na_cycles);
    endtask

    task automatic test_ignore;
        logic [7:0] e, o;
        for (int i = 0; i < 3; i++) exp_q.push_back(tb_table[i]);
        do_start(2'd1, 8'h00, 6'd3);
        run_seq(1'b1, -1, 1, 30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL ignore_ssid: missing, want %02h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL ignore_ssid: got %02h want %02h", o, e); end end
        end
        n_vec++; if (seqCount !== 16'd3) begin n_err++; $display("FAIL ignore_seqcount: got %0d want 3", seqCount); end
        exp_q.push_back(tb_table[0]);
        do_start(2'd1, 8'h00, 6'd1);
        run_seq(1'b0, -1, -1, 10);
        n_vec++;
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hXX;
        e = exp_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL ignore_table_write: got %02h want %02h", o, e); end
        $display("ignore: run-time write/start ignored, entry0 %02h", o);
    endtask

    task automatic test_clamp;
        logic [7:0] e, o;
        for (int i = 0; i < 32; i++) write_entry(5'(i), 8'(i * 7 + 3));
        for (int i = 0; i < 32; i++) exp_q.push_back(tb_table[i]);
        do_start(2'd1, 8'h00, 6'd40);
        run_seq(1'b0, -1, -1, 60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL clamp_ssid: missing, want %02h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL clamp_ssid: got %02h want %02h", o, e); end end
        end
        n_vec++; if (seqCount !== 16'd32) begin n_err++; $display("FAIL clamp_seqcount: got %0d want 32", seqCount); end
        $display("clamp: tableLen 40 delivered %0d entries", seqCount);
    endtask

    task automatic test_reset_mid;
        logic [7:0] e, o;
        do_start(2'd1, 8'h00, 6'd32);
        storageReady = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        n_vec++; if (newAddress !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            begin n_err++; $display("FAIL rstmid_flags: got na=%b busy=%b done=%b want 000", newAddress, busy, done); end
        n_vec++; if (SSID !== 8'h00 || hitInfo !== 16'h0000 || seqCount !== 16'd0)
            begin n_err++; $display("FAIL rstmid_values: got ssid=%02h hit=%04h cnt=%0d want 0", SSID, hitInfo, seqCount); end
        @(posedge clock); #1;
        reset = 1'b0; storageReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got done=%b busy=%b want 0 0", done, busy); end
        end
        @(posedge clock); #1;
        for (int i = 0; i < 5; i++) exp_q.push_back(tb_table[i]);
        do_start(2'd1, 8'h00, 6'd5);
        run_seq(1'b1, -1, -1, 30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL rstmid_replay: missing, want %02h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL rstmid_replay: got %02h want %02h", o, e); end end
        end
        n_vec++; if (seqCount !== 16'd5) begin n_err++; $display("FAIL rstmid_seqcount: got %0d want 5", seqCount); end
        $display("reset_mid: outputs cleared, replay of 5 entries");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; countLimit = 8'h00;
        tableLen = 6'd0; tableWrEn = 1'b0; tableWrAddr = 5'd0; tableWrData = 8'h00;
        storageReady = 1'b0;
        test_reset();
        test_count("count", 2'd0, 8'd5);
        test_count("mode3", 2'd3, 8'd2);
        test_table_once();
        test_write_start();
        test_loop();
        test_len0();
        test_ignore();
        test_clamp();
        test_count("count_wrap", 2'd0, 8'hFF);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
